// File: rtl/multicycle_subtractor_pkg.sv
// subtractor_pkg: shared types and constants for the multicycle subtractor.
//   state_t     - controller states (IDLE, BUSY, DONE)
//   SLICE_W     - width of the shared look-ahead slice
//   slice_count - number of slices (compute cycles) for a given operand width
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/multicycle_subtractor_if.sv
// multicycle_subtractor_if: operand and result handshakes of the subtractor.
//   Handshake rule (both sides): a transfer happens on a rising clock edge
//   where valid and ready are both 1. The source holds valid and its data
//   steady until that edge; ready may be asserted independently of valid.
//   Signals:
//     in_valid/in_ready      operand handshake
//     minuend/subtrahend     WIDTH-bit unsigned operands
//     borrow_in              incoming borrow
//     out_valid/out_ready    result handshake
//     difference/borrow_out  result
//     zero/overflow          result flags (only with SUBTRACTOR_FLAGS_EN)
//   Modports: master = operand producer / result consumer, slave = subtractor.
interface multicycle_subtractor_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
`ifdef SUBTRACTOR_FLAGS_EN
  logic             zero;
  logic             overflow;
`endif

  modport master (
    output in_valid, minuend, subtrahend, borrow_in, out_ready,
    input  in_ready, out_valid, difference, borrow_out
`ifdef SUBTRACTOR_FLAGS_EN
    , input zero, overflow
`endif
  );

  modport slave (
    input  in_valid, minuend, subtrahend, borrow_in, out_ready,
    output in_ready, out_valid, difference, borrow_out
`ifdef SUBTRACTOR_FLAGS_EN
    , output zero, overflow
`endif
  );

endinterface

// File: rtl/multicycle_subtractor_borrow_lookahead_4bit.sv
// borrow_lookahead_4bit: combinational 4-bit subtract slice with borrow
// look-ahead.
//   a, b : slice operands (computes a - b - bin)
//   bin  : borrow into bit 0
//   d    : slice difference
//   bout : borrow out of bit 3
module borrow_lookahead_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // g: this bit generates a borrow; p: this bit passes the incoming borrow.
  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Every borrow is expanded back to bin so no bit waits on its neighbour.
  assign c[0] = bin;
  assign c[1] = g[0] | (p[0] & bin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d    = a ^ b ^ c[3:0];
  assign bout = c[4];

endmodule

// File: rtl/multicycle_subtractor.sv
// multicycle_subtractor: computes minuend - subtrahend - borrow_in one 4-bit
// slice per clock through a single shared borrow_lookahead_4bit.
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       slave side of multicycle_subtractor_if (operands in, result out)
//   state_dbg current controller state
// Optional macro SUBTRACTOR_FLAGS_EN adds the zero and overflow flags.
module multicycle_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_subtractor_if.slave  bus,
  output state_t                  state_dbg
);

  localparam int SLICES = slice_count(WIDTH);
  localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(SLICES - 1);

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_next;
  logic             borrow_q;
  logic             borrow_out_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [SLICE_W-1:0] a_s;
  logic [SLICE_W-1:0] b_s;
  logic [SLICE_W-1:0] d_s;
  logic               bout_s;

  assign a_s = a_q[k*SLICE_W +: SLICE_W];
  assign b_s = b_q[k*SLICE_W +: SLICE_W];

  borrow_lookahead_4bit u_slice (
    .a    (a_s),
    .b    (b_s),
    .bin  (borrow_q),
    .d    (d_s),
    .bout (bout_s)
  );

  // Result register with the current slice merged in; on the last slice this
  // is the final difference, which the zero flag needs in the same edge.
  always_comb begin
    diff_next = diff_q;
    diff_next[k*SLICE_W +: SLICE_W] = d_s;
  end

`ifdef SUBTRACTOR_FLAGS_EN
  logic zero_q;
  logic overflow_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
`ifdef SUBTRACTOR_FLAGS_EN
      zero_q       <= 1'b0;
      overflow_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // in_ready comes up one edge after reset release.
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.minuend;
            b_q        <= bus.subtrahend;
            borrow_q   <= bus.borrow_in;
            k          <= '0;
            in_ready_q <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          diff_q   <= diff_next;
          borrow_q <= bout_s;
          k        <= k + 1'b1;
          if (k == LAST_K) begin
            borrow_out_q <= bout_s;
            out_valid_q  <= 1'b1;
            state        <= DONE;
`ifdef SUBTRACTOR_FLAGS_EN
            zero_q     <= (diff_next == '0);
            overflow_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_s[SLICE_W-1] != a_q[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          // in_ready rises with the result handshake, so the next accept is
          // at least one edge later.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.difference = diff_q;
  assign bus.borrow_out = borrow_out_q;
`ifdef SUBTRACTOR_FLAGS_EN
  assign bus.zero       = zero_q;
  assign bus.overflow   = overflow_q;
`endif
  assign state_dbg      = state;

endmodule
